demux8_tdm_rx: RTL and testbench
================================

// Module: demux8_tdm_rx
// PURPOSE
//  Time-division 1:8 demultiplexer / frame reassembler, the receive end of the mux8_1 path.
//  - Drives the slot select s[2:0], which feeds the remote mux8_1 s2..s0.
//  - Samples the serial mux output din once per enabled cycle.
//  - Rebuilds the 8 parallel inputs i0..i7 as one registered word dout[7:0]: bit k = ik.
//  - Marks each completed word with a one-cycle valid pulse.
// PARAMETERS
//  N     8  slots per frame (number of mux inputs); must be a power of 2, >= 2
//  SW    3  select width, = log2(N)
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst        in   1    synchronous reset, active-high
//  en         in   1    sample din into the current slot and advance the slot
//  sync       in   1    frame restart: the next sample belongs to slot 0
//  din        in   1    serial data; the mux output y for the slot s currently presented
//  s          out  SW   current slot select; s[2]=s2, s[1]=s1, s[0]=s0 of the mux
//  dout       out  N    last complete frame; dout[k] = sample taken in slot k
//  dout_valid out  1    1-cycle pulse: dout updated this cycle
//  sync_err   out  1    1-cycle pulse: sync aborted a partial frame
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - s=0, dout=0, dout_valid=0, sync_err=0; internal shadow[N-1:0]=0.
//   - Reset applies mid-frame: the partial frame is discarded with no sync_err.
//   - rst has priority over all other inputs.
//  Slot timing:
//   - s is a registered output.
//   - The external mux decodes s combinationally and returns din in the same cycle.
//   - Therefore the sample taken at a posedge is the data for the slot s held just before that edge.
//  en=1, sync=0:
//   - shadow[s] <= din.
//   - If s != N-1: s <= s+1.
//   - If s == N-1: dout <= {din, shadow[N-2:0]}, dout_valid <= 1, s <= 0 (wrap).
//  en=0, sync=0: s, shadow and dout hold; dout_valid <= 0.
//  sync=1, en=0:
//   - s <= 0; shadow cleared.
//   - sync_err <= 1 iff s != 0 (partial frame lost).
//  sync=1, en=1 (same cycle):
//   - The frame restarts on this sample: shadow <= 0 with shadow[0] <= din, s <= 1.
//   - sync_err <= 1 iff s != 0.
//   - No dout update, even if s == N-1 (that frame is aborted).
//  Pulses: dout_valid and sync_err are high for exactly one cycle and default to 0 on every other cycle.
//  Latency: dout/dout_valid appear at the posedge that samples slot N-1, i.e. N enabled samples after slot 0.
//  Throughput: with en held high, one frame every N cycles; back-to-back frames need no gap cycle.
//  dout holds its value between frames; it is never partially updated.
//  s wraps N-1 -> 0 only through frame completion, sync or rst; it never exceeds N-1.
// TESTING
//  1 Reset:
//    - Drive rst=1 for 2 cycles with en=1 and din=1.
//    - Required: s=0, dout=8'h00, dout_valid=0, sync_err=0.
//  2 Single frame:
//    - Loop back through a mux8_1 model with i0..i7=0,1,0,1,0,0,0,1 and en=1 for 8 cycles.
//    - Required: s steps 0..7; dout=8'h8A with dout_valid=1 for exactly 1 cycle; s=0 afterwards.
//  3 Back-to-back frames:
//    - Hold en=1 for 16 cycles; change the i-vector to 8'hF0 for frame 2.
//    - Required: dout=8'h8A at cycle 8 and 8'hF0 at cycle 16, with no gap.
//  4 Stall:
//    - Run frame 2 again with en deasserted for 3 cycles after slot 3.
//    - Required: s holds at 4; dout stays 8'h8A until completion, then 8'hF0.
//  5 Mid-frame sync:
//    - After 5 samples, pulse sync with en=0.
//    - Required: sync_err=1 for 1 cycle; s=0; no dout_valid.
//    - Then 8 samples of 8'h3C -> dout=8'h3C.
//  6 Sync with en at s=7:
//    - Required: no dout_valid; sync_err=1; s=1; shadow[0] = din.
//    - Also: rst at s=4 -> s=0, no pulses.

Source files
------------

// File: rtl/demux8_tdm_rx.sv
// Receive end of a TDM mux8_1 link: drives the slot select, samples the serial
// return line, and reassembles each frame into a parallel word with a valid pulse.
module demux8_tdm_rx #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic          din,
    output logic [SW-1:0] s,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    output logic          sync_err
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);

    logic [N-1:0]  shadow;
    logic [N-1:0]  shadow_nxt;
    logic [SW-1:0] s_nxt;
    logic [N-1:0]  dout_nxt;
    logic          dout_valid_nxt;
    logic          sync_err_nxt;

    // Next-state: sync aborts or restarts the frame; otherwise en samples into slot s.
    always_comb begin
        s_nxt          = s;
        shadow_nxt     = shadow;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        sync_err_nxt   = 1'b0;

        if (sync) begin
            sync_err_nxt = (s != '0);
            shadow_nxt   = '0;
            if (en) begin
                shadow_nxt[0] = din;
                s_nxt         = SW'(1);
            end else begin
                s_nxt = '0;
            end
        end else if (en) begin
            shadow_nxt[s] = din;
            if (s == LAST_SLOT) begin
                // Whole word moves at once so dout is never seen half-updated.
                dout_nxt       = shadow_nxt;
                dout_valid_nxt = 1'b1;
                s_nxt          = '0;
            end else begin
                s_nxt = s + SW'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s          <= '0;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            s          <= s_nxt;
            shadow     <= shadow_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            sync_err   <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_demux8_tdm_rx.sv
// Directed bench for demux8_tdm_rx with a mux8_1 loopback model on din.
module tb_demux8_tdm_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sync;
    logic       din;
    logic [2:0] s;
    logic [7:0] dout;
    logic       dout_valid;
    logic       sync_err;

    logic [7:0] ivec;
    logic       use_mux;
    logic       din_man;
    int         tests_run  = 0;
    int         tests_fail = 0;

    always #5 clk = ~clk;

    // Remote mux8_1: y = i[s], combinational.
    assign din = use_mux ? ivec[s] : din_man;

    demux8_tdm_rx #(.N(8), .SW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync       (sync),
        .din        (din),
        .s          (s),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_err   (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic sy);
        en   = e;
        sync = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] es, input logic [7:0] ed,
                             input logic ev, input logic ee);
        check({tag, ".s"},    32'(s),          32'(es));
        check({tag, ".dout"}, 32'(dout),       32'(ed));
        check({tag, ".vld"},  32'(dout_valid), 32'(ev));
        check({tag, ".err"},  32'(sync_err),   32'(ee));
    endtask

    // Runs n enabled samples starting from slot `first`, checking s before each edge.
    task automatic run_samples(input string tag, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            check({tag, ".s_pre"}, 32'(s), 32'((first + k) % 8));
            step(1'b1, 1'b0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        sync    = 1'b0;
        use_mux = 1'b0;
        din_man = 1'b1;
        ivec    = 8'h00;

        // 1 Reset with en and din high.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_out("reset", 3'd0, 8'h00, 1'b0, 1'b0);
        rst     = 1'b0;
        en      = 1'b0;
        use_mux = 1'b1;
        step(1'b0, 1'b0);
        check_out("reset_idle", 3'd0, 8'h00, 1'b0, 1'b0);

        // 2 Single frame i0..i7 = 0,1,0,1,0,0,0,1 -> 8'h8A.
        ivec = 8'h8A;
        run_samples("frame1", 0, 7);
        check_out("frame1_pre", 3'd7, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_out("frame1_done", 3'd0, 8'h8A, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_out("frame1_pulse_end", 3'd0, 8'h8A, 1'b0, 1'b0);

        // 3 Back-to-back frames, no gap.
        ivec = 8'h8A;
        run_samples("b2b_a", 0, 8);
        check_out("b2b_a_done", 3'd0, 8'h8A, 1'b1, 1'b0);
        ivec = 8'hF0;
        run_samples("b2b_b", 0, 7);
        check_out("b2b_b_pre", 3'd7, 8'h8A, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_out("b2b_b_done", 3'd0, 8'hF0, 1'b1, 1'b0);

        // 4 Stall after slot 3.
        ivec = 8'h8A;
        run_samples("stall_prime", 0, 8);
        check_out("stall_prime_done", 3'd0, 8'h8A, 1'b1, 1'b0);
        ivec = 8'hF0;
        run_samples("stall_head", 0, 4);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            check_out("stall_hold", 3'd4, 8'h8A, 1'b0, 1'b0);
        end
        run_samples("stall_tail", 4, 3);
        check_out("stall_tail_pre", 3'd7, 8'h8A, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_out("stall_done", 3'd0, 8'hF0, 1'b1, 1'b0);

        // 5 Mid-frame sync with en low, then a clean frame.
        ivec = 8'hFF;
        run_samples("msync_head", 0, 5);
        step(1'b0, 1'b1);
        check_out("msync", 3'd0, 8'hF0, 1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_out("msync_pulse_end", 3'd0, 8'hF0, 1'b0, 1'b0);
        ivec = 8'h3C;
        run_samples("msync_frame", 0, 8);
        check_out("msync_frame_done", 3'd0, 8'h3C, 1'b1, 1'b0);

        // Sync at slot 0 loses nothing.
        step(1'b0, 1'b1);
        check_out("sync_s0", 3'd0, 8'h3C, 1'b0, 1'b0);

        // 6 Sync with en at s=7: frame aborted, restarts on this sample.
        ivec = 8'hFF;
        run_samples("sync7_head", 0, 7);
        check_out("sync7_pre", 3'd7, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        check_out("sync7", 3'd1, 8'h3C, 1'b0, 1'b1);
        // Complete the restarted frame with zeros: only shadow[0] = 1 survives.
        ivec = 8'h00;
        run_samples("sync7_tail", 1, 7);
        check_out("sync7_done", 3'd0, 8'h01, 1'b1, 1'b0);

        // Reset mid-frame at s=4: no pulses, all cleared.
        ivec = 8'hA5;
        run_samples("rst4_head", 0, 4);
        check("rst4_pre.s", 32'(s), 32'd4);
        rst = 1'b1;
        step(1'b1, 1'b0);
        check_out("rst4", 3'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        check_out("rst4_idle", 3'd0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
